clear_sequencer: RTL

- Power-on and software-requested clear controller for DFFC-based register banks. It drives the asynchronous CLEAR inputs of up to NUM_STAGES register groups.
- Clear assertion is immediate and asynchronous. Release is synchronous, held for a minimum time, then staggered one group at a time so downstream pipelines leave clear in a fixed order.
- Sits between the board or global reset and every DFFC/DFFCE clear net in the design.

---
 rtl/clear_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/clear_sequencer.sv
// Clear sequencer for DFFC register banks: asynchronous assertion on CLEAR,
// synchronized release, a minimum hold, then staggered per-group release.
module clear_sequencer #(
   parameter int NUM_STAGES  = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int STAGE_GAP   = 4,
   parameter int SYNC_DEPTH  = 2
) (
   input  logic                  CLK,
   input  logic                  CLEAR,
   input  logic                  SW_REQ,
   output logic                  SW_ACK,
   output logic [NUM_STAGES-1:0] CLR_OUT,
   output logic                  READY,
   output logic                  BUSY
);

   localparam int MAX_COUNT = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
   localparam int CW        = $clog2(MAX_COUNT) + 1;
   localparam int IW        = $clog2(NUM_STAGES) + 1;

   localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(STAGE_GAP - 1);
   localparam logic [IW-1:0] LAST_STAGE = IW'(NUM_STAGES - 1);

   typedef enum logic [1:0] {
      ST_HOLD  = 2'b00,
      ST_STAGE = 2'b01,
      ST_IDLE  = 2'b10
   } state_t;

   logic [SYNC_DEPTH-1:0] sync_r;
   logic                  sync_clr_s;
   state_t                state_r, state_s;
   logic [CW-1:0]         cnt_r, cnt_s;
   logic [IW-1:0]         idx_r, idx_s;
   logic [NUM_STAGES-1:0] clr_r, clr_s;
   logic                  ready_r, ready_s;
   logic                  busy_r, busy_s;
   logic                  ack_r, ack_s;
   logic                  sw_q_r;

   assign sync_clr_s = sync_r[SYNC_DEPTH-1];

   // CLEAR deassertion synchronizer: zeros shift in once CLEAR is low
   always_ff @(posedge CLK or posedge CLEAR) begin
      if (CLEAR) begin
         sync_r <= {SYNC_DEPTH{1'b1}};
      end else begin
         sync_r <= {sync_r[SYNC_DEPTH-2:0], 1'b0};
      end
   end

   // Next-state and next-output logic; every release shifts one more zero into CLR_OUT
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      idx_s   = idx_r;
      clr_s   = clr_r;
      ready_s = ready_r;
      busy_s  = busy_r;
      ack_s   = 1'b0;
      case (state_r)
         ST_HOLD: begin
            if (sync_clr_s) begin
               cnt_s = {CW{1'b0}};
            end else if (cnt_r == HOLD_LAST) begin
               cnt_s = {CW{1'b0}};
               idx_s = {IW{1'b0}};
               clr_s = clr_r << 1'b1;
               if (LAST_STAGE == {IW{1'b0}}) begin
                  state_s = ST_IDLE;
                  ready_s = 1'b1;
                  ack_s   = busy_r;
                  busy_s  = 1'b0;
               end else begin
                  state_s = ST_STAGE;
               end
            end else begin
               cnt_s = cnt_r + CW'(1);
            end
         end
         ST_STAGE: begin
            if (cnt_r == GAP_LAST) begin
               cnt_s = {CW{1'b0}};
               idx_s = idx_r + IW'(1);
               clr_s = clr_r << 1'b1;
               if (idx_s == LAST_STAGE) begin
                  state_s = ST_IDLE;
                  ready_s = 1'b1;
                  ack_s   = busy_r;
                  busy_s  = 1'b0;
               end else begin
                  state_s = ST_STAGE;
               end
            end else begin
               cnt_s = cnt_r + CW'(1);
            end
         end
         ST_IDLE: begin
            // only a fresh rising level of SW_REQ starts a software sequence
            if (SW_REQ && !sw_q_r) begin
               state_s = ST_HOLD;
               cnt_s   = {CW{1'b0}};
               idx_s   = {IW{1'b0}};
               clr_s   = {NUM_STAGES{1'b1}};
               ready_s = 1'b0;
               busy_s  = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         default: begin
            state_s = ST_HOLD;
            cnt_s   = {CW{1'b0}};
            idx_s   = {IW{1'b0}};
            clr_s   = {NUM_STAGES{1'b1}};
            ready_s = 1'b0;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State and output registers; CLEAR forces every clear net high at once
   always_ff @(posedge CLK or posedge CLEAR) begin
      if (CLEAR) begin
         state_r <= ST_HOLD;
         cnt_r   <= {CW{1'b0}};
         idx_r   <= {IW{1'b0}};
         clr_r   <= {NUM_STAGES{1'b1}};
         ready_r <= 1'b0;
         busy_r  <= 1'b0;
         ack_r   <= 1'b0;
         sw_q_r  <= 1'b1;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         idx_r   <= idx_s;
         clr_r   <= clr_s;
         ready_r <= ready_s;
         busy_r  <= busy_s;
         ack_r   <= ack_s;
         sw_q_r  <= SW_REQ;
      end
   end

   assign CLR_OUT = clr_r;
   assign READY   = ready_r;
   assign BUSY    = busy_r;
   assign SW_ACK  = ack_r;

endmodule
